// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ps2_pkg                                                |
// | Description : Shared PS/2 types, frame constants and parity helper.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ps2_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_TX_HI   = 4'd1,
        ST_TX_LO   = 4'd2,
        ST_RX_WAIT = 4'd3,
        ST_RX_LO   = 4'd4,
        ST_RX_HI   = 4'd5,
        ST_ACK_LO  = 4'd6,
        ST_ACK_HI  = 4'd7,
        ST_GAP     = 4'd8
    } ps2_state_e;

    // start + 8 data + parity + stop
    localparam int unsigned c_FRAME_LEN = 11;

    // Odd parity bit: makes the total count of ones over data+parity odd
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ps2_sync                                               |
// | Description : Two-flop synchroniser for one PS/2 line. Resets to the |
// |               released (high) level so no false edge follows reset. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ps2_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_line
);

    logic r_meta_q;
    logic r_sync_q;

    // Two-stage resynchronisation of the asynchronous line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta_q <= 1'b1;
            r_sync_q <= 1'b1;
        end else begin
            r_meta_q <= i_line;
            r_sync_q <= r_meta_q;
        end
    end

    assign o_line = r_sync_q;

endmodule
`default_nettype wire

// File: rtl/ps2_device_emulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ps2_device_emulator                                    |
// | Description : Device (keyboard) side of a PS/2 link. Generates the   |
// |               PS/2 clock, sends bytes to the host, detects host      |
// |               request-to-send, receives host bytes and ACKs them.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ps2_device_emulator
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 2000,
    parameter int unsigned SETUP       = 500,
    parameter int unsigned INHIBIT_MIN = 5000,
    parameter int unsigned GAP         = 4000
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        ps2clk,
    inout  wire        ps2data,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_error,
    output logic       busy
);

    localparam int unsigned c_MAX_AB  = (CLK_DIV > INHIBIT_MIN) ? CLK_DIV : INHIBIT_MIN;
    localparam int unsigned c_MAX_CNT = (c_MAX_AB > GAP) ? c_MAX_AB : GAP;
    localparam int unsigned c_CW      = $clog2(c_MAX_CNT + 1);

    localparam logic [c_CW-1:0] c_DIV_LAST   = c_CW'(CLK_DIV - 1);
    localparam logic [c_CW-1:0] c_SETUP_LAST = c_CW'(SETUP - 1);
    localparam logic [c_CW-1:0] c_GAP_LAST   = c_CW'(GAP - 1);
    localparam logic [c_CW-1:0] c_INHIBIT    = c_CW'(INHIBIT_MIN);
    localparam logic [c_CW-1:0] c_LOW_SAT    = {c_CW{1'b1}};
    // The synced clock still shows our own low phase for two cycles after release
    localparam logic [c_CW-1:0] c_SYNC_MASK  = c_CW'(3);
    localparam logic [3:0]      c_LAST_BIT   = 4'(c_FRAME_LEN - 1);
    localparam logic [3:0]      c_LAST_SMPL  = 4'(c_FRAME_LEN - 2);

    logic w_clk_s;
    logic w_data_s;

    ps2_sync u_sync_clk  (.clk(clk), .rst(rst), .i_line(ps2clk),  .o_line(w_clk_s));
    ps2_sync u_sync_data (.clk(clk), .rst(rst), .i_line(ps2data), .o_line(w_data_s));

    ps2_state_e        r_state_q,    w_state_d;
    logic [c_CW-1:0]   r_cnt_q,      w_cnt_d;
    logic [c_CW-1:0]   r_low_q,      w_low_d;
    logic [3:0]        r_idx_q,      w_idx_d;
    logic              r_full_q,     w_full_d;
    logic [7:0]        r_tx_byte_q,  w_tx_byte_d;
    logic [9:0]        r_rx_shift_q, w_rx_shift_d;
    logic [7:0]        r_rx_data_q,  w_rx_data_d;
    logic              r_rx_error_q, w_rx_error_d;
    logic              r_rx_valid_q, w_rx_valid_d;
    logic              r_clk_drv_q,  w_clk_drv_d;
    logic              r_data_drv_q, w_data_drv_d;

    logic [c_FRAME_LEN-1:0] w_frame;
    logic                   w_rx_err;

    assign w_frame  = {1'b1, odd_parity(r_tx_byte_q), r_tx_byte_q, 1'b0};
    // Shift register holds data[7:0], parity at [8], stop at [9]
    assign w_rx_err = (r_rx_shift_q[8] != odd_parity(r_rx_shift_q[7:0])) || !r_rx_shift_q[9];

    // Next-state, frame sequencing and line-drive decisions
    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q + 1'b1;
        w_low_d      = '0;
        w_idx_d      = r_idx_q;
        w_full_d     = r_full_q;
        w_tx_byte_d  = r_tx_byte_q;
        w_rx_shift_d = r_rx_shift_q;
        w_rx_data_d  = r_rx_data_q;
        w_rx_error_d = r_rx_error_q;
        w_rx_valid_d = 1'b0;
        w_data_drv_d = r_data_drv_q;

        if (tx_valid && !r_full_q) begin
            w_full_d    = 1'b1;
            w_tx_byte_d = tx_data;
        end

        case (r_state_q)
            ST_IDLE: begin
                w_cnt_d      = '0;
                w_data_drv_d = 1'b0;
                if (!w_clk_s) begin
                    w_low_d = (r_low_q == c_LOW_SAT) ? r_low_q : r_low_q + 1'b1;
                end else if (r_low_q >= c_INHIBIT && !w_data_s) begin
                    w_state_d = ST_RX_WAIT;
                end else if (r_full_q && w_data_s) begin
                    w_state_d = ST_TX_HI;
                    w_idx_d   = '0;
                end
            end
            ST_TX_HI: begin
                if (!w_clk_s && r_cnt_q >= c_SYNC_MASK && r_idx_q < c_LAST_BIT) begin
                    // Host inhibit: drop the frame, keep the byte for a full retry
                    w_state_d    = ST_IDLE;
                    w_data_drv_d = 1'b0;
                end else if (r_cnt_q == c_DIV_LAST) begin
                    w_state_d = ST_TX_LO;
                end else if (r_cnt_q == c_SETUP_LAST) begin
                    w_data_drv_d = ~w_frame[r_idx_q];
                end
            end
            ST_TX_LO: begin
                if (r_cnt_q == c_DIV_LAST) begin
                    if (r_idx_q == c_LAST_BIT) begin
                        w_state_d    = ST_GAP;
                        w_full_d     = 1'b0;
                        w_data_drv_d = 1'b0;
                    end else begin
                        w_idx_d   = r_idx_q + 1'b1;
                        w_state_d = ST_TX_HI;
                    end
                end
            end
            ST_RX_WAIT: begin
                if (r_cnt_q == c_DIV_LAST) begin
                    w_state_d = ST_RX_LO;
                    w_idx_d   = '0;
                end
            end
            ST_RX_LO: begin
                if (r_cnt_q == c_DIV_LAST) begin
                    w_state_d = ST_RX_HI;
                end
            end
            ST_RX_HI: begin
                if (r_cnt_q == c_SETUP_LAST && r_idx_q < c_LAST_BIT) begin
                    w_rx_shift_d = {w_data_s, r_rx_shift_q[9:1]};
                end
                if (r_cnt_q == c_DIV_LAST) begin
                    if (r_idx_q == c_LAST_BIT) begin
                        // Extra pulse after a bad stop bit is done
                        w_state_d    = ST_GAP;
                        w_rx_valid_d = 1'b1;
                        w_rx_data_d  = r_rx_shift_q[7:0];
                        w_rx_error_d = w_rx_err;
                    end else if (r_idx_q == c_LAST_SMPL) begin
                        if (r_rx_shift_q[9]) begin
                            w_state_d    = ST_ACK_LO;
                            w_data_drv_d = 1'b1;
                        end else begin
                            w_state_d = ST_RX_LO;
                            w_idx_d   = c_LAST_BIT;
                        end
                    end else begin
                        w_idx_d   = r_idx_q + 1'b1;
                        w_state_d = ST_RX_LO;
                    end
                end
            end
            ST_ACK_LO: begin
                if (r_cnt_q == c_DIV_LAST) begin
                    w_state_d = ST_ACK_HI;
                end
            end
            ST_ACK_HI: begin
                if (r_cnt_q == c_SETUP_LAST) begin
                    w_data_drv_d = 1'b0;
                end
                if (r_cnt_q == c_DIV_LAST) begin
                    w_state_d    = ST_GAP;
                    w_rx_valid_d = 1'b1;
                    w_rx_data_d  = r_rx_shift_q[7:0];
                    w_rx_error_d = w_rx_err;
                end
            end
            ST_GAP: begin
                w_data_drv_d = 1'b0;
                if (r_cnt_q == c_GAP_LAST) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d    = ST_IDLE;
                w_data_drv_d = 1'b0;
            end
        endcase

        if (w_state_d != r_state_q) begin
            w_cnt_d = '0;
        end

        w_clk_drv_d = (w_state_d == ST_TX_LO) || (w_state_d == ST_RX_LO) ||
                      (w_state_d == ST_ACK_LO);
    end

    // State, counters, holding register and line-drive registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_cnt_q      <= '0;
            r_low_q      <= '0;
            r_idx_q      <= '0;
            r_full_q     <= 1'b0;
            r_tx_byte_q  <= '0;
            r_rx_shift_q <= '0;
            r_rx_data_q  <= '0;
            r_rx_error_q <= 1'b0;
            r_rx_valid_q <= 1'b0;
            r_clk_drv_q  <= 1'b0;
            r_data_drv_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_low_q      <= w_low_d;
            r_idx_q      <= w_idx_d;
            r_full_q     <= w_full_d;
            r_tx_byte_q  <= w_tx_byte_d;
            r_rx_shift_q <= w_rx_shift_d;
            r_rx_data_q  <= w_rx_data_d;
            r_rx_error_q <= w_rx_error_d;
            r_rx_valid_q <= w_rx_valid_d;
            r_clk_drv_q  <= w_clk_drv_d;
            r_data_drv_q <= w_data_drv_d;
        end
    end

    // Open-drain: pull low or float, never drive high
    assign ps2clk  = r_clk_drv_q  ? 1'b0 : 1'bz;
    assign ps2data = r_data_drv_q ? 1'b0 : 1'bz;

    assign tx_ready = !r_full_q;
    assign rx_valid = r_rx_valid_q;
    assign rx_data  = r_rx_data_q;
    assign rx_error = r_rx_error_q;
    assign busy     = (r_state_q != ST_IDLE);

endmodule
`default_nettype wire
